// File: rtl/crc24_attach.sv
// crc24_attach: forwards a serial block and appends the CRC24A read back from an external crc24 stage.
module crc24_attach #(
  parameter int LEN_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_data,
  input  logic             s_sop,
  input  logic [LEN_W-1:0] blk_len,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_data,
  output logic             m_sop,
  output logic             m_eop,
  output logic             m_is_crc,
  output logic             crc_init,
  output logic             crc_en,
  output logic             crc_din,
  output logic             crc_nen_shift,
  input  logic [23:0]      crc_in,
  output logic             err
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_DATA, S_WAIT, S_CRC} state_t;
  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [4:0]       r_bitcnt;
  logic [23:0]      r_crc_sr;
  logic             r_first;
  logic             r_m_valid;
  logic             r_m_data;
  logic             r_m_sop;
  logic             r_m_eop;
  logic             r_m_is_crc;
  logic             r_err;
  logic             w_free;
  logic             w_xfer;
  always_comb begin
    w_free        = !r_m_valid || m_ready;
    s_ready       = (r_state == S_IDLE) ? (!s_sop || blk_len == '0) :
                    (r_state == S_DATA) ? w_free : 1'b0;
    w_xfer        = s_valid && s_ready;
    crc_init      = r_state == S_INIT;
    crc_en        = (r_state == S_DATA) && w_xfer;
    crc_din       = crc_en && s_data;
    crc_nen_shift = 1'b1;
  end
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_sop    = r_m_sop;
  assign m_eop    = r_m_eop;
  assign m_is_crc = r_m_is_crc;
  assign err      = r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bitcnt   <= '0;
      r_crc_sr   <= '0;
      r_first    <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= 1'b0;
      r_m_sop    <= 1'b0;
      r_m_eop    <= 1'b0;
      r_m_is_crc <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      // a consumed slot empties unless a new bit is loaded below
      if (w_free) begin
        r_m_valid  <= 1'b0;
        r_m_sop    <= 1'b0;
        r_m_eop    <= 1'b0;
        r_m_is_crc <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (s_valid) begin
          if (!s_sop || blk_len == '0) r_err <= 1'b1;
          else begin
            r_cnt   <= blk_len;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_first <= 1'b1;
          r_state <= S_DATA;
        end
        S_DATA: if (w_xfer) begin
          r_m_data   <= s_data;
          r_m_valid  <= 1'b1;
          r_m_sop    <= r_first;
          r_m_is_crc <= 1'b0;
          r_first    <= 1'b0;
          r_err      <= s_sop && !r_first;
          r_cnt      <= r_cnt - 1'b1;
          if (r_cnt == LEN_W'(1)) r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_crc_sr <= crc_in;
          r_bitcnt <= 5'd24;
          r_state  <= S_CRC;
        end
        S_CRC: if (w_free) begin
          r_m_data   <= r_crc_sr[23];
          r_crc_sr   <= {r_crc_sr[22:0], 1'b0};
          r_m_valid  <= 1'b1;
          r_m_is_crc <= 1'b1;
          r_m_eop    <= r_bitcnt == 5'd1;
          r_bitcnt   <= r_bitcnt - 1'b1;
          if (r_bitcnt == 5'd1) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc24_attach.sv
// tb_crc24_attach: scoreboard bench with a behavioural crc24 stage wired to the controller.
module tb_crc24_attach;
  localparam int LEN_W = 13;
  logic clk = 0, rst_n = 0;
  logic s_valid = 0, s_ready, s_data = 0, s_sop = 0;
  logic [LEN_W-1:0] blk_len = '0;
  logic m_valid, m_ready = 1, m_data, m_sop, m_eop, m_is_crc;
  logic crc_init, crc_en, crc_din, crc_nen_shift, err;
  logic [23:0] env_crc;
  int errors = 0, checks = 0, cyc = 0, rcv_cnt = 0, err_cnt = 0, init_cnt = 0, en_cnt = 0, sop_cyc = 0;
  logic [3:0] expq[$];
  int eop_q[$];
  logic rx[$];
  bit rx_en = 0, bp = 0;

  crc24_attach #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sop(s_sop), .blk_len(blk_len), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sop(m_sop), .m_eop(m_eop), .m_is_crc(m_is_crc), .crc_init(crc_init), .crc_en(crc_en),
    .crc_din(crc_din), .crc_nen_shift(crc_nen_shift), .crc_in(env_crc), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) env_crc <= '0;
    else if (crc_init) env_crc <= '0;
    else if (crc_en) env_crc <= {env_crc[22:0], 1'b0} ^ ((crc_din ^ env_crc[23]) ? 24'h864CFB : 24'h0);

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1 m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    logic [3:0] e;
    err_cnt += int'(err);
    init_cnt += int'(crc_init);
    en_cnt += int'(crc_en);
    if (m_valid && m_ready) begin
      rcv_cnt++;
      if (rx_en) rx.push_back(m_data);
      if (m_eop) eop_q.push_back(cyc);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %b%b%b%b with nothing expected", m_data, m_sop, m_eop, m_is_crc);
      end else begin
        e = expq.pop_front();
        chk("out {data,sop,eop,is_crc}", {28'h0, m_data, m_sop, m_eop, m_is_crc}, {28'h0, e});
      end
    end
  end

  function automatic logic [23:0] crc_of(input logic [0:63] b, input int n);
    logic [23:0] c = '0;
    for (int i = 0; i < n; i++) begin
      logic fb;
      fb = b[i] ^ c[23];
      c = {c[22:0], 1'b0};
      if (fb) c = c ^ 24'h864CFB;
    end
    return c;
  endfunction

  task automatic send_block(input int n, input logic [0:63] b, input logic [23:0] c, input int sop_at, input bit keep);
    int t;
    bit hs;
    for (int i = 0; i < n; i++) expq.push_back({b[i], i == 0, 1'b0, 1'b0});
    for (int k = 0; k < 24; k++) expq.push_back({c[23-k], 1'b0, k == 23, 1'b1});
    for (int i = 0; i < n; i++) begin
      s_valid = 1;
      s_sop = (i == 0) || (i == sop_at);
      blk_len = LEN_W'(n);
      s_data = b[i];
      t = 0;
      hs = 0;
      while (!hs && t < 3000) begin
        @(negedge clk);
        hs = s_ready;
        if (hs && i == 0) sop_cyc = cyc;
        @(posedge clk);
        #1 t++;
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: bit %0d never accepted", i);
        s_valid = 0;
        return;
      end
    end
    if (!keep) begin
      s_valid = 0;
      s_sop = 0;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (expq.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 chk(name, expq.size(), 0);
  endtask

  initial begin
    logic [0:63] b, rb;
    int e0, r0, i0, n0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst m_valid", m_valid, 0);
    chk("rst m_data", m_data, 0);
    chk("rst flags", {m_sop, m_eop, m_is_crc, err}, 0);
    chk("rst crc ctl", {crc_init, crc_en, crc_din}, 0);
    chk("rst nen_shift", crc_nen_shift, 1);
    rst_n = 1;
    @(posedge clk);
    #1;
    i0 = init_cnt; n0 = en_cnt;
    b = {1'b1, 63'b0};
    send_block(1, b, 24'h864CFB, -1, 0);
    drain("blk1 drain");
    chk("blk1 init pulses", init_cnt - i0, 1);
    chk("blk1 en pulses", en_cnt - n0, 1);
    b = {2'b10, 62'b0};
    send_block(2, b, 24'h8AD50D, -1, 0);
    drain("blk2 drain");
    b = '0;
    send_block(8, b, 24'h000000, -1, 0);
    drain("blk8z drain");
    e0 = err_cnt; r0 = rcv_cnt;
    s_valid = 1; s_sop = 0; s_data = 1;
    @(posedge clk);
    #1 s_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("err nonsop", err_cnt - e0, 1);
    chk("nonsop no output", rcv_cnt - r0, 0);
    e0 = err_cnt; r0 = rcv_cnt;
    s_valid = 1; s_sop = 1; blk_len = '0;
    @(posedge clk);
    #1 s_valid = 0; s_sop = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("err len0", err_cnt - e0, 1);
    chk("len0 no output", rcv_cnt - r0, 0);
    e0 = err_cnt;
    b = {4'b1011, 60'b0};
    send_block(4, b, crc_of(b, 4), 2, 0);
    drain("midsop drain");
    chk("err midsop", err_cnt - e0, 1);
    for (int i = 0; i < 64; i++) b[i] = (i < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
    rx.delete();
    rx_en = 1; bp = 1;
    send_block(40, b, crc_of(b, 40), -1, 0);
    drain("rand drain");
    bp = 0; rx_en = 0;
    chk("rand out count", rx.size(), 64);
    rb = '0;
    for (int i = 0; i < 64 && i < rx.size(); i++) rb[i] = rx[i];
    chk("rand residue", crc_of(rb, 64), 0);
    r0 = rcv_cnt;
    b = {1'b1, 63'b0};
    send_block(1, b, 24'h864CFB, -1, 0);
    begin
      int t = 0;
      while (rcv_cnt < r0 + 11 && t < 200) begin
        @(negedge clk);
        #1 t++;
      end
    end
    @(posedge clk);
    #2 chk("pre-rst in crc", {m_valid, m_is_crc}, 2'b11);
    rst_n = 0;
    #1;
    chk("midrst m_valid", m_valid, 0);
    chk("midrst flags", {m_data, m_sop, m_eop, m_is_crc}, 0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1 i0 = init_cnt;
    send_block(1, b, 24'h864CFB, -1, 0);
    drain("postrst drain");
    chk("postrst init", init_cnt - i0, 1);
    eop_q.delete();
    b = {2'b10, 62'b0};
    send_block(2, b, 24'h8AD50D, -1, 1);
    b = {1'b1, 63'b0};
    send_block(1, b, 24'h864CFB, -1, 0);
    drain("b2b drain");
    chk("b2b eops", eop_q.size(), 2);
    if (eop_q.size() > 0) chk("b2b sop after eop", sop_cyc > eop_q[0], 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crc24_attach.md
Name: crc24_attach

Overview:
- Transport-block CRC attachment controller sitting directly around the crc24 generator stage: drives its control inputs (init, en_com, d_in, nen_shift) and consumes its parallel crc_out.
- Accepts a serial bit stream with valid/ready handshake and forwards it unchanged.
- After the last data bit, appends the 24-bit CRC24A (poly 0x864CFB, zero init) MSB first.
- Feeds the code-block segmentation stage downstream.

Parameters:
- LEN_W, 13, width of blk_len; max block length 2^LEN_W-1 data bits.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset; also routed to the crc24 instance aclr (inverted)
- s_valid  in  1  input bit valid
- s_ready  out  1  input bit accepted when s_valid&&s_ready
- s_data  in  1  input data bit
- s_sop  in  1  first bit of a block; qualifies blk_len
- blk_len  in  LEN_W  number of data bits in block, sampled with s_sop in IDLE
- m_valid  out  1  output bit valid (registered)
- m_ready  in  1  downstream accept
- m_data  out  1  output bit (registered)
- m_sop  out  1  first data bit of block
- m_eop  out  1  last CRC bit of block
- m_is_crc  out  1  current output bit is a CRC bit
- crc_init  out  1  to crc24 init (synchronous set to zero)
- crc_en  out  1  to crc24 en_com
- crc_din  out  1  to crc24 d_in
- crc_nen_shift  out  1  to crc24 nen_shift; constant 1 (parallel update mode)
- crc_in  in  24  from crc24 crc_out
- err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset: state=IDLE, all outputs 0 except crc_nen_shift=1; counters and CRC latch cleared. Reset mid-block aborts immediately with no partial CRC; the next block starts clean.
- The crc24 generator updates on the edge where crc_en=1: new state = (state<<1) ^ (0x864CFB if d^state[23]). The CRC is valid on crc_in the cycle after the last update.
- Output slot free: free = !m_valid || m_ready. A bit is consumed on any cycle with m_valid&&m_ready; m_valid drops if nothing new is loaded.
- IDLE:
  - s_ready = !s_sop.
  - Non-sop beats are discarded with an err pulse.
  - s_valid&&s_sop&&blk_len==0: beat consumed (s_ready=1), err pulse, remain IDLE.
  - s_valid&&s_sop&&blk_len!=0: latch cnt=blk_len, go INIT; the sop beat is not consumed here.
- INIT: crc_init=1 for exactly one cycle -> DATA.
- DATA:
  - s_ready = free.
  - On transfer: crc_en=1 and crc_din=s_data (combinational, same cycle); m_data<=s_data, m_valid<=1, m_sop<=first bit, m_is_crc<=0; cnt--.
  - s_sop on a non-first bit: err pulse, bit still processed as data.
  - Transfer with cnt==1 -> WAIT.
- WAIT: one cycle; latch crc_sr<=crc_in, bitcnt=24 -> CRC. s_ready=0.
- CRC:
  - When free: m_data<=crc_sr[23], crc_sr<<=1, m_valid<=1, m_is_crc<=1, bitcnt--.
  - m_eop<=1 on bitcnt==1; after that bit is loaded -> IDLE.
  - s_ready=0 throughout CRC.
- Latency:
  - Input bit accepted at cycle t appears on m_data at t+1.
  - Unstalled block of N bits: sop seen (1) + INIT (1) + N + WAIT (1) + 24 cycles.
  - The next sop can be detected the cycle after the last CRC bit is loaded.
- Backpressure: m_ready low holds m_data/m_valid/flags stable and blocks further transfers; counters freeze.
- crc_en is never asserted outside DATA transfers. crc_init is asserted only in INIT.

Test Plan:
- blk_len=1, data=1, m_ready=1 -> 25 output bits: 1, then CRC 0x864CFB MSB first (1000 0110 0100 1100 1111 1011); m_sop on bit0, m_eop on bit24, m_is_crc on bits 1-24.
- blk_len=2, data=1,0 -> CRC 0x8AD50D appended; blk_len=8 all zeros -> CRC 0x000000.
- Random 40-bit block, random m_ready backpressure -> output equals input followed by the CRC. A second pass through a golden CRC24A model over all 64 bits gives residue 0. No output bit is duplicated or lost.
- Protocol errors:
  - Non-sop beat in IDLE -> err pulse, beat dropped, no output.
  - sop with blk_len=0 -> err pulse, no output.
  - s_sop mid-block -> err pulse, block length unchanged.
- Assert rst_n low during CRC bit 10 of a block -> outputs 0 immediately. A following blk_len=1 data=1 block yields 0x864CFB (crc_init re-issued).
- Back-to-back blocks with s_valid held high -> second block's sop is accepted only after the first block's m_eop. Both CRCs are correct.
